// File: rtl/rd_req_fifo_bank.sv
// rd_req_fifo_bank: two per-master read request FIFOs, each drained by a 4-phase req/ack issuer.
module rd_req_fifo_bank #(
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [1:0]          in_wren,
  input  logic [AWIDTH-1:0]   in_addr,
  output logic                fifo_full,
  output logic [1:0]          ovf,
  output logic [1:0]          m_req,
  output logic [2*AWIDTH-1:0] m_addr,
  output logic [1:0]          m_cmd,
  input  logic [1:0]          m_ack
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, RELEASE} state_t;
  logic illegal;
  logic [1:0][CW-1:0] next_count;
  assign illegal = &in_wren;
  assign m_cmd = '0;
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [AWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [AWIDTH-1:0] addr_r;
    logic req_r, ovf_r, pop, push;
    state_t state;
    assign pop = (state == IDLE) && (count != '0);
    // a pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
    assign push = in_wren[i] && !illegal && ((count != CW'(DEPTH)) || pop);
    assign next_count[i] = count + CW'(push) - CW'(pop);
    assign m_req[i] = req_r;
    assign ovf[i] = ovf_r;
    assign m_addr[i*AWIDTH +: AWIDTH] = addr_r;
    always_ff @(posedge aclk)
      if (push) mem[wptr] <= in_addr;
    always_ff @(posedge aclk)
      if (areset) begin
        wptr   <= '0;
        rptr   <= '0;
        count  <= '0;
        ovf_r  <= 1'b0;
        req_r  <= 1'b0;
        addr_r <= '0;
        state  <= IDLE;
      end else begin
        count <= next_count[i];
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        if (illegal || (in_wren[i] && !push)) ovf_r <= 1'b1;
        case (state)
          IDLE: if (pop) begin
            addr_r <= mem[rptr];
            state  <= LOAD;
          end
          LOAD: begin
            req_r <= 1'b1;
            state <= ISSUE;
          end
          ISSUE: if (m_ack[i]) begin
            req_r <= 1'b0;
            state <= RELEASE;
          end
          RELEASE: if (!m_ack[i]) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
  end
  always_ff @(posedge aclk)
    if (areset) fifo_full <= 1'b0;
    else fifo_full <= (next_count[0] == CW'(DEPTH)) || (next_count[1] == CW'(DEPTH));
endmodule

// File: tb/tb_rd_req_fifo_bank.sv
// tb_rd_req_fifo_bank: vector table, directed corner sequences and a randomized queue-model run.
module tb_rd_req_fifo_bank;
  localparam int AW = 32;
  localparam int DP = 4;
  logic aclk, areset, fifo_full;
  logic [1:0] in_wren, m_ack, ovf, m_req, m_cmd;
  logic [AW-1:0] in_addr;
  logic [2*AW-1:0] m_addr;
  int total = 0, passed = 0;
  logic [AW-1:0] q[2][$];
  int pushed[2], issued[2];

  typedef struct packed {
    logic [1:0]    wren;
    logic [AW-1:0] addr;
    logic [1:0]    ack;
    logic [1:0]    req;
    logic          full;
    logic [1:0]    ovf;
    logic [AW-1:0] a0;
  } vec_t;
  vec_t tv[9];

  rd_req_fifo_bank #(.AWIDTH(AW), .DEPTH(DP)) dut (
    .aclk(aclk), .areset(areset), .in_wren(in_wren), .in_addr(in_addr),
    .fifo_full(fifo_full), .ovf(ovf), .m_req(m_req), .m_addr(m_addr),
    .m_cmd(m_cmd), .m_ack(m_ack)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [AW-1:0] a_of(input int i);
    return m_addr[i*AW +: AW];
  endfunction

  task automatic do_reset;
    areset = 1'b1;
    in_wren = '0;
    m_ack = '0;
    tick;
    areset = 1'b0;
  endtask

  task automatic push1(input int i, input logic [AW-1:0] a);
    in_wren = '0;
    in_wren[i] = 1'b1;
    in_addr = a;
    tick;
    in_wren = '0;
  endtask

  // full 4-phase handshake on master i, expecting address exp
  task automatic hs(input int i, input logic [AW-1:0] exp, input string nm);
    int n;
    n = 0;
    while (!m_req[i] && n < 20) begin
      tick;
      n++;
    end
    chk({nm, "_req"}, 64'(m_req[i]), 64'd1);
    chk({nm, "_addr"}, 64'(a_of(i)), 64'(exp));
    m_ack[i] = 1'b1;
    n = 0;
    do begin
      tick;
      n++;
    end while (m_req[i] && n < 20);
    chk({nm, "_drop"}, 64'(m_req[i]), 64'd0);
    m_ack[i] = 1'b0;
    tick;
  endtask

  task automatic quiet(input int n, input logic [1:0] mask, input string nm);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick;
      seen |= |(m_req & mask);
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  task automatic rnd_step(input bit allow_push);
    int r;
    logic [1:0] preq, pack;
    logic [AW-1:0] paddr[2];
    in_wren = '0;
    r = int'($urandom_range(0, 3));
    if (allow_push && (r == 1 || r == 2) && (pushed[r-1] - issued[r-1] < DP)) begin
      in_wren[r-1] = 1'b1;
      in_addr = $urandom;
      q[r-1].push_back(in_addr);
      pushed[r-1]++;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_req[i] && !m_ack[i] && $urandom_range(0, 2) == 0) m_ack[i] = 1'b1;
      else if (!m_req[i] && m_ack[i] && $urandom_range(0, 1) == 0) m_ack[i] = 1'b0;
      paddr[i] = a_of(i);
    end
    preq = m_req;
    pack = m_ack;
    tick;
    for (int i = 0; i < 2; i++) begin
      if (preq[i]) begin
        chk("rnd_req_hold", 64'(m_req[i]), 64'(!pack[i]));
        if (m_req[i]) chk("rnd_addr_stable", 64'(a_of(i)), 64'(paddr[i]));
      end else if (m_req[i]) begin
        if (q[i].size() == 0) begin
          total++;
          $display("FAIL rnd_spurious: master %0d issued %0h with nothing queued", i, a_of(i));
        end else begin
          chk("rnd_addr", 64'(a_of(i)), 64'(q[i].pop_front()));
          issued[i]++;
        end
      end
    end
  endtask

  initial begin
    tv[0] = '{2'b01, 32'h10, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0};
    tv[1] = '{2'b00, 32'h0,  2'b00, 2'b00, 1'b0, 2'b00, 32'h10};
    tv[2] = '{2'b00, 32'h0,  2'b00, 2'b01, 1'b0, 2'b00, 32'h10};
    tv[3] = '{2'b00, 32'h0,  2'b00, 2'b01, 1'b0, 2'b00, 32'h10};
    tv[4] = '{2'b00, 32'h0,  2'b01, 2'b00, 1'b0, 2'b00, 32'h10};
    tv[5] = '{2'b00, 32'h0,  2'b01, 2'b00, 1'b0, 2'b00, 32'h10};
    tv[6] = '{2'b00, 32'h0,  2'b00, 2'b00, 1'b0, 2'b00, 32'h10};
    tv[7] = '{2'b00, 32'h0,  2'b01, 2'b00, 1'b0, 2'b00, 32'h10};
    tv[8] = '{2'b00, 32'h0,  2'b00, 2'b00, 1'b0, 2'b00, 32'h10};
    areset = 1'b1;
    in_wren = '0;
    in_addr = '0;
    m_ack = '0;
    tick;
    tick;
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_req", 64'(m_req), 64'd0);
    chk("rst_addr", m_addr, 64'd0);
    chk("rst_cmd", 64'(m_cmd), 64'd0);
    areset = 1'b0;
    // single push, latency and handshake
    for (int k = 0; k < 9; k++) begin
      in_wren = tv[k].wren;
      in_addr = tv[k].addr;
      m_ack = tv[k].ack;
      tick;
      chk($sformatf("vec%0d_req", k), 64'(m_req), 64'(tv[k].req));
      chk($sformatf("vec%0d_full", k), 64'(fifo_full), 64'(tv[k].full));
      chk($sformatf("vec%0d_ovf", k), 64'(ovf), 64'(tv[k].ovf));
      chk($sformatf("vec%0d_a0", k), 64'(a_of(0)), 64'(tv[k].a0));
      chk($sformatf("vec%0d_a1", k), 64'(a_of(1)), 64'd0);
    end
    // fill and overflow on FIFO 1
    m_ack = '0;
    for (int k = 0; k < 5; k++) begin
      push1(1, 32'h8000_0000 + 32'(k));
      if (k == 3) chk("fill_full_pre", 64'(fifo_full), 64'd0);
      if (k == 4) chk("fill_full", 64'(fifo_full), 64'd1);
    end
    push1(1, 32'h8000_0005);
    chk("fill_ovf", 64'(ovf), 64'b10);
    chk("fill_full_hold", 64'(fifo_full), 64'd1);
    chk("fill_req", 64'(m_req), 64'b10);
    chk("fill_head", 64'(a_of(1)), 64'h8000_0000);
    for (int k = 0; k < 5; k++) hs(1, 32'h8000_0000 + 32'(k), $sformatf("fill%0d", k));
    quiet(20, 2'b10, "fill_dropped_not_issued");
    chk("fill_full_end", 64'(fifo_full), 64'd0);
    // simultaneous push and pop at full on FIFO 0
    do_reset;
    push1(0, 32'h0000_0200);
    tick;
    tick;
    chk("pp_x0_req", 64'(m_req[0]), 64'd1);
    m_ack[0] = 1'b1;
    tick;
    for (int k = 1; k <= 4; k++) push1(0, 32'h100 + 32'(k));
    chk("pp_full", 64'(fifo_full), 64'd1);
    m_ack[0] = 1'b0;
    tick;
    chk("pp_full_idle", 64'(fifo_full), 64'd1);
    push1(0, 32'h105);
    chk("pp_full_same", 64'(fifo_full), 64'd1);
    chk("pp_ovf", 64'(ovf), 64'd0);
    for (int k = 1; k <= 5; k++) hs(0, 32'h100 + 32'(k), $sformatf("pp%0d", k));
    // independence: master 0 stalled, master 1 proceeds
    do_reset;
    push1(0, 32'h0000_0A0A);
    push1(1, 32'h8000_0B0B);
    hs(1, 32'h8000_0B0B, "indep1");
    chk("indep0_req", 64'(m_req[0]), 64'd1);
    chk("indep0_addr", 64'(a_of(0)), 64'h0000_0A0A);
    // illegal strobe pushes nothing
    in_wren = 2'b11;
    in_addr = 32'hDEAD_BEEF;
    tick;
    in_wren = '0;
    chk("illegal_ovf", 64'(ovf), 64'b11);
    hs(0, 32'h0000_0A0A, "indep0");
    quiet(20, 2'b11, "illegal_no_push");
    chk("illegal_full", 64'(fifo_full), 64'd0);
    // reset while a request is outstanding
    push1(0, 32'h11);
    push1(0, 32'h22);
    push1(0, 32'h33);
    tick;
    chk("mid_pre_req", 64'(m_req), 64'b01);
    chk("mid_pre_ovf", 64'(ovf), 64'b11);
    areset = 1'b1;
    tick;
    areset = 1'b0;
    chk("mid_req", 64'(m_req), 64'd0);
    chk("mid_full", 64'(fifo_full), 64'd0);
    chk("mid_ovf", 64'(ovf), 64'd0);
    chk("mid_addr", m_addr, 64'd0);
    quiet(15, 2'b11, "mid_discard");
    // randomized traffic against queue model
    do_reset;
    pushed = '{0, 0};
    issued = '{0, 0};
    for (int c = 0; c < 3000; c++) rnd_step(1'b1);
    for (int c = 0; c < 300; c++) rnd_step(1'b0);
    chk("rnd_drain0", 64'(q[0].size()), 64'd0);
    chk("rnd_drain1", 64'(q[1].size()), 64'd0);
    chk("rnd_ovf", 64'(ovf), 64'd0);
    chk("rnd_cmd", 64'(m_cmd), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
